ser2par: RTL
============

# ser2par

Serial-to-parallel packer: accepts SERWIDTH-bit beats on a valid/ready stream and assembles them into PARWIDTH-bit words on a second valid/ready stream. It is the receive-side counterpart of the parallel-to-serial stage. It sits directly downstream of a serial link or serializer and rebuilds the original word, using the same lane ordering convention. It sustains one beat per clock with no bubbles while the output side is not back-pressured.

## Interface
- SERWIDTH, 8: serial beat width in bits.
- PARWIDTH, 32: parallel word width in bits.
  - Must be an integer multiple of SERWIDTH.
  - N = PARWIDTH/SERWIDTH, with 2 ≤ N ≤ 255.
- DATA_ORDER, 1: lane order.
  - 1: first beat lands in par_dout[SERWIDTH-1:0] (LSB lane first).
  - 0: first beat lands in par_dout[PARWIDTH-1:PARWIDTH-SERWIDTH] (MSB lane first).
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ser_valid  input  1  a serial beat is offered.
- ser_ready  output  1  the packer can take a beat this cycle.
- ser_din  input  SERWIDTH  serial beat data.
- par_valid  output  1  par_dout holds a complete word.
- par_ready  input  1  downstream takes the word this cycle.
- par_dout  output  PARWIDTH  assembled word.
- ser_last  input  1  final beat of a packet (only with SER2PAR_LAST_EN).
- par_lanes  output  8  number of valid lanes in par_dout, range 1..N (only with SER2PAR_LAST_EN).

## Operation
- Datapath:
  - Accumulator register (PARWIDTH) and beat counter beat_cnt (8 bit, 0..N-1).
  - One output holding register (par_dout/par_valid); out_full is par_valid.
- Handshakes:
  - A beat is accepted when ser_valid && ser_ready.
  - A word is transferred when par_valid && par_ready.
- Placement of an accepted beat:
  - DATA_ORDER=1: ser_din is written into lane beat_cnt; lane k occupies bits [k*SERWIDTH +: SERWIDTH].
  - DATA_ORDER=0: ser_din is written into lane N-1-beat_cnt.
- Completing beat (beat_cnt==N-1):
  - The accumulator contents plus this beat load into par_dout on the same edge.
  - par_valid rises; beat_cnt wraps to 0.
  - The accumulator is cleared to 0.
- Non-completing beat: beat_cnt increments.
- ser_ready = !(beat_cnt==N-1 && par_valid && !par_ready).
  - This is combinational from par_ready and is intentional.
  - Only the completing beat can stall; the accumulator keeps absorbing the first N-1 beats while a word waits.
- par_valid:
  - Falls on a transfer edge unless a completing beat is accepted on the same edge.
  - If a completing beat is accepted on that edge, the new word replaces the old one and par_valid stays 1.
- par_dout and par_lanes hold stable while par_valid && !par_ready.
- ser_valid without ser_ready: nothing changes.
- ser_din is ignored when no beat is accepted.

## Timing
- Reset values:
  - par_valid=0, par_dout=0, par_lanes=0.
  - beat_cnt=0, accumulator=0.
  - ser_ready=1 (combinational, follows from the reset state).
- Latency: par_valid is asserted on the clock edge that accepts the completing beat, so the word is visible in the cycle after the last beat's handshake.
- Throughput: with par_ready held 1, N·k beats in N·k consecutive cycles yield k words, with no stall cycles.
- Reset mid-word: partial accumulator content and any pending output word are discarded. The first beat after rst_n rises starts a fresh word at lane 0 (or lane N-1 when DATA_ORDER=0).

## Configuration
- SER2PAR_LAST_EN defined:
  - ser_last and par_lanes ports exist.
  - A beat accepted with ser_last=1 is treated as completing regardless of beat_cnt, and follows the same stall rule as beat_cnt==N-1.
  - par_lanes is loaded with beat_cnt+1.
  - Unfilled lanes are 0.
  - beat_cnt returns to 0.
  - Full words report par_lanes=N.
- SER2PAR_LAST_EN undefined:
  - ser_last and par_lanes ports are absent.
  - Every output word is full.

## Test plan
- DATA_ORDER=1, par_ready=1, beats 0x11,0x22,0x33,0x44 in consecutive cycles -> par_valid=1 for one cycle after the 4th handshake, par_dout=0x44332211.
- DATA_ORDER=0, same beats -> par_dout=0x11223344.
- par_ready=0 with one word pending, 4 more beats offered -> 3 beats accepted; ser_ready=0 on the 4th until par_ready=1. The 4th is accepted in the same cycle as that transfer; the old word is transferred and the new word appears next cycle with par_valid still 1.
- Continuous streaming: 8 beats 0x01..0x08 in 8 cycles with par_ready=1 -> ser_ready never drops; words 0x04030201 then 0x08070605.
- Reset mid-word: accept 0xAA,0xBB, pulse rst_n low, then send 0x01..0x04 -> par_dout=0x04030201; no trace of 0xAA/0xBB; par_valid=0 throughout reset.
- SER2PAR_LAST_EN, DATA_ORDER=1: beats 0xAA, 0xBB with ser_last=1 -> par_dout=0x0000BBAA, par_lanes=2. The next 4 beats yield par_lanes=4.

Source files
------------

// File: rtl/ser2par.sv
// Serial-to-parallel packer: SERWIDTH-bit beats in, PARWIDTH-bit words out.
// Optional packet-end handling via `define SER2PAR_LAST_EN (ser_last/par_lanes).
module ser2par #(
  parameter int SERWIDTH   = 8,
  parameter int PARWIDTH   = 32,
  parameter int DATA_ORDER = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ser_valid,
  output logic                ser_ready,
  input  logic [SERWIDTH-1:0] ser_din,
  output logic                par_valid,
  input  logic                par_ready,
  output logic [PARWIDTH-1:0] par_dout
`ifdef SER2PAR_LAST_EN
  ,
  input  logic                ser_last,
  output logic [7:0]          par_lanes
`endif
);

  localparam int N = PARWIDTH / SERWIDTH;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);

  logic [7:0]          beat_cnt;
  logic [7:0]          lane;
  logic [PARWIDTH-1:0] acc;
  logic [PARWIDTH-1:0] merged;
  logic                done;
  logic                accept;
  logic                xfer;

`ifdef SER2PAR_LAST_EN
  assign done = (beat_cnt == LAST_IDX) || ser_last;
`else
  assign done = (beat_cnt == LAST_IDX);
`endif

  // Only the completing beat can stall; earlier beats go to the accumulator.
  assign ser_ready = !(done && par_valid && !par_ready);
  assign accept    = ser_valid && ser_ready;
  assign xfer      = par_valid && par_ready;

  assign lane = (DATA_ORDER != 0) ? beat_cnt : (LAST_IDX - beat_cnt);

  always_comb begin
    merged = acc;
    for (int k = 0; k < N; k++) begin
      if (lane == 8'(k)) begin
        merged[k*SERWIDTH +: SERWIDTH] = ser_din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      acc      <= '0;
    end else if (accept) begin
      if (done) begin
        beat_cnt <= '0;
        acc      <= '0;
      end else begin
        beat_cnt <= beat_cnt + 8'd1;
        acc      <= merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_valid <= 1'b0;
      par_dout  <= '0;
    end else if (accept && done) begin
      par_valid <= 1'b1;
      par_dout  <= merged;
    end else if (xfer) begin
      par_valid <= 1'b0;
    end
  end

`ifdef SER2PAR_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_lanes <= '0;
    end else if (accept && done) begin
      par_lanes <= beat_cnt + 8'd1;
    end
  end
`endif

endmodule
